cla_wide_add_seq: RTL and testbench
===================================

// Module: cla_wide_add_seq
// PURPOSE
//   Sequencer that runs wide (NUM_WORDS*DATA_WID-bit) add/subtract operations
//   through one shared DATA_WID-bit cpu_wb_cla_adder, one word per clock, LSW first.
//   The carry is registered between words. Requests and results use valid/ready handshakes.
//   Sits between the writeback-stage requester and the adder instance; the adder stays combinational.
// PARAMETERS
//   DATA_WID   16  width of the shared adder slice (bits)
//   NUM_WORDS  4   words per operation (>=2); operand width W = DATA_WID*NUM_WORDS
// PORTS
//   clk        in   1          clock, all state on rising edge
//   rst_n      in   1          asynchronous active-low reset
//   req_valid  in   1          request present
//   req_ready  out  1          sequencer can accept (high only in IDLE)
//   req_sub    in   1          0: a+b, 1: a-b
//   req_a      in   W          operand a
//   req_b      in   W          operand b
//   add_in1    out  DATA_WID   to adder in1
//   add_in2    out  DATA_WID   to adder in2
//   add_cin    out  1          to adder carry_in
//   add_sum    in   DATA_WID   from adder sum
//   add_cout   in   1          from adder carry_out
//   rsp_valid  out  1          result valid (high only in DONE)
//   rsp_ready  in   1          consumer takes result
//   rsp_sum    out  W          result
//   rsp_cout   out  1          final carry out; for sub, 1 = no borrow
//   rsp_ovf    out  1          two's-complement signed overflow
//   busy       out  1          state != IDLE
// BEHAVIOUR
//   Reset (async on rst_n fall):
//     - state=IDLE, req_ready=1, rsp_valid=0, busy=0.
//     - rsp_sum=0, rsp_cout=0, rsp_ovf=0, add_in1/add_in2/add_cin=0.
//     - Reset mid-operation aborts it. No response is ever produced for an aborted operation.
//   States IDLE, RUN, DONE. Word index idx counts 0..NUM_WORDS-1.
//   IDLE:
//     - Accept on req_valid&&req_ready (cycle T).
//     - Latch a and b_eff (b_eff = sub ? ~b : b), set carry=req_sub, set idx=0, go to RUN.
//   RUN:
//     - add_in1 = a[idx], add_in2 = b_eff[idx], add_cin = carry. All are driven from registers.
//     - Each cycle: sum[idx] <= add_sum, carry <= add_cout, idx++.
//     - After capturing word NUM_WORDS-1, go to DONE.
//     - rsp_cout = final add_cout.
//     - rsp_ovf = (a_msb==b_eff_msb) && (sum_msb!=a_msb).
//   DONE:
//     - rsp_valid=1. rsp_sum/cout/ovf are stable until rsp_valid&&rsp_ready, then go to IDLE.
//     - No accept in the same cycle as the response handshake.
//   Timing:
//     - RUN occupies T+1..T+NUM_WORDS; rsp_valid first high at T+NUM_WORDS+1.
//     - Minimum spacing between accepts is NUM_WORDS+2 cycles.
//   Handshake and port rules:
//     - Outside RUN, add_in1/add_in2/add_cin are driven 0.
//     - req_valid is ignored while busy. rsp_ready without rsp_valid is ignored.
//     - rsp_sum keeps its last result after the handshake and is overwritten only by the next
//       completion.
//   Arithmetic:
//     - Arithmetic is modulo 2^W. Inputs change nothing outside the accept cycle.
// TESTING (NUM_WORDS=4, DATA_WID=16)
//   1. Pull rst_n low in the 2nd RUN cycle. Immediately: req_ready=1, busy=0, add_*=0.
//      rsp_valid stays 0 for 20 cycles.
//   2. a=64'h0000_0000_0000_FFFF + b=1:
//      - rsp_sum=64'h0000_0000_0001_0000, cout=0, ovf=0, rsp_valid at T+5.
//      - add_cin per RUN cycle = 0,1,0,0.
//   3. a=b=64'hFFFF_FFFF_FFFF_FFFF add -> rsp_sum=64'hFFFF_FFFF_FFFF_FFFE, cout=1, ovf=0.
//   4. a=64'h7FFF_FFFF_FFFF_FFFF + b=1 -> rsp_sum=64'h8000_0000_0000_0000, cout=0, ovf=1.
//   5. Subtract:
//      - 0-1 -> rsp_sum=64'hFFFF_FFFF_FFFF_FFFF, cout=0.
//      - 5-3 -> rsp_sum=2, cout=1. Both ovf=0.
//   6. Hold rsp_ready=0 for 10 cycles with req_valid=1:
//      - rsp_valid/data stay stable, req_ready=0, no second accept.
//      - After a rsp_ready pulse: IDLE next cycle, next request accepted the cycle after.

Source files
------------

// File: rtl/cla_wide_add_seq.sv
// Wide add/subtract sequencer: feeds one DATA_WID-bit slice per clock, LSW first,
// through an external combinational adder and registers the carry between words.
module cla_wide_add_seq #(
  parameter int unsigned DATA_WID  = 16,
  parameter int unsigned NUM_WORDS = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic                          req_sub,
  input  logic [DATA_WID*NUM_WORDS-1:0] req_a,
  input  logic [DATA_WID*NUM_WORDS-1:0] req_b,
  output logic [DATA_WID-1:0]           add_in1,
  output logic [DATA_WID-1:0]           add_in2,
  output logic                          add_cin,
  input  logic [DATA_WID-1:0]           add_sum,
  input  logic                          add_cout,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [DATA_WID*NUM_WORDS-1:0] rsp_sum,
  output logic                          rsp_cout,
  output logic                          rsp_ovf,
  output logic                          busy
);

  localparam int unsigned W     = DATA_WID * NUM_WORDS;
  localparam int unsigned HW    = W - DATA_WID;
  localparam int unsigned IDX_W = (NUM_WORDS > 2) ? $clog2(NUM_WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              r_state;
  logic [HW-1:0]       r_a_hi;
  logic [HW-1:0]       r_b_hi;
  logic [HW-1:0]       r_acc;
  logic [IDX_W-1:0]    r_idx;
  logic [DATA_WID-1:0] r_in1;
  logic [DATA_WID-1:0] r_in2;
  logic                r_cin;
  logic [W-1:0]        r_sum;
  logic                r_cout;
  logic                r_ovf;
  logic                r_req_ready;
  logic                r_rsp_valid;
  logic                r_busy;

  logic [W-1:0]        w_b_eff;
  logic                w_a_msb;
  logic                w_b_msb;

  assign w_b_eff = req_sub ? ~req_b : req_b;
  assign w_a_msb = r_a_hi[HW-1];
  assign w_b_msb = r_b_hi[HW-1];

  // Word 0 goes straight into the adder input registers at accept; only words
  // 1..NUM_WORDS-1 are held, so r_a_hi/r_b_hi word i is operand word i+1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_a_hi      <= '0;
      r_b_hi      <= '0;
      r_acc       <= '0;
      r_idx       <= '0;
      r_in1       <= '0;
      r_in2       <= '0;
      r_cin       <= 1'b0;
      r_sum       <= '0;
      r_cout      <= 1'b0;
      r_ovf       <= 1'b0;
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_a_hi      <= req_a[W-1:DATA_WID];
            r_b_hi      <= w_b_eff[W-1:DATA_WID];
            r_in1       <= req_a[DATA_WID-1:0];
            r_in2       <= w_b_eff[DATA_WID-1:0];
            r_cin       <= req_sub;
            r_idx       <= '0;
            r_state     <= S_RUN;
            r_req_ready <= 1'b0;
            r_busy      <= 1'b1;
          end
        end
        S_RUN: begin
          if (r_idx == LAST_IDX) begin
            r_sum       <= {add_sum, r_acc};
            r_cout      <= add_cout;
            r_ovf       <= (w_a_msb == w_b_msb) && (add_sum[DATA_WID-1] != w_a_msb);
            r_in1       <= '0;
            r_in2       <= '0;
            r_cin       <= 1'b0;
            r_state     <= S_DONE;
            r_rsp_valid <= 1'b1;
          end else begin
            r_acc[r_idx*DATA_WID +: DATA_WID] <= add_sum;
            r_in1 <= r_a_hi[r_idx*DATA_WID +: DATA_WID];
            r_in2 <= r_b_hi[r_idx*DATA_WID +: DATA_WID];
            r_cin <= add_cout;
            r_idx <= r_idx + IDX_W'(1);
          end
        end
        S_DONE: begin
          if (rsp_ready) begin
            r_state     <= S_IDLE;
            r_rsp_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_req_ready <= 1'b1;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_in1       <= '0;
          r_in2       <= '0;
          r_cin       <= 1'b0;
          r_rsp_valid <= 1'b0;
          r_busy      <= 1'b0;
          r_req_ready <= 1'b1;
        end
      endcase
    end
  end

  assign req_ready = r_req_ready;
  assign rsp_valid = r_rsp_valid;
  assign busy      = r_busy;
  assign add_in1   = r_in1;
  assign add_in2   = r_in2;
  assign add_cin   = r_cin;
  assign rsp_sum   = r_sum;
  assign rsp_cout  = r_cout;
  assign rsp_ovf   = r_ovf;

endmodule

// File: tb/tb_cla_wide_add_seq.sv
// Bench for cla_wide_add_seq: behavioural adder slice, cycle-level reference model,
// directed boundary cases and randomized operations.
module tb_cla_wide_add_seq;

  localparam int unsigned DW = 16;
  localparam int unsigned NW = 4;
  localparam int unsigned W  = DW * NW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          req_valid, req_ready, req_sub;
  logic [W-1:0]  req_a, req_b;
  logic [DW-1:0] add_in1, add_in2, add_sum;
  logic          add_cin, add_cout;
  logic          rsp_valid, rsp_ready;
  logic [W-1:0]  rsp_sum;
  logic          rsp_cout, rsp_ovf, busy;
  logic [DW:0]   adder_full;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  // The shared slice adder lives outside the sequencer.
  always_comb begin
    adder_full = {1'b0, add_in1} + {1'b0, add_in2} + {{DW{1'b0}}, add_cin};
    add_sum    = adder_full[DW-1:0];
    add_cout   = adder_full[DW];
  end

  cla_wide_add_seq #(.DATA_WID(DW), .NUM_WORDS(NW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_sub(req_sub),
    .req_a(req_a), .req_b(req_b),
    .add_in1(add_in1), .add_in2(add_in2), .add_cin(add_cin),
    .add_sum(add_sum), .add_cout(add_cout),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_sum(rsp_sum), .rsp_cout(rsp_cout), .rsp_ovf(rsp_ovf), .busy(busy)
  );

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] ref_sum(input logic [W-1:0] a, b, input logic sub);
    return sub ? (a - b) : (a + b);
  endfunction

  function automatic logic ref_cout(input logic [W-1:0] a, b, input logic sub);
    logic [W:0] t;
    t = {1'b0, a} + {1'b0, b};
    return sub ? (a >= b) : t[W];
  endfunction

  function automatic logic ref_ovf(input logic [W-1:0] a, b, input logic sub);
    logic signed [W:0] sa, sb, r;
    sa = {a[W-1], a};
    sb = {b[W-1], b};
    r  = sub ? (sa - sb) : (sa + sb);
    return r[W] != r[W-1];
  endfunction

  // Carry entering word k = carry out of the low k words of the operation.
  function automatic logic carry_into(input logic [W-1:0] a, b, input logic sub, input int k);
    logic [W:0] mask, la, lb;
    if (k == 0) return sub;
    mask = ({{W{1'b0}}, 1'b1} << (k * DW)) - 1;
    la = {1'b0, a} & mask;
    lb = {1'b0, b} & mask;
    if (sub) return la >= lb;
    return (la + lb) > mask;
  endfunction

  // Reference model: phase 0 idle, 1..NW = RUN cycle, NW+1 = response pending.
  int           m_phase = 0;
  logic [W-1:0] m_a = '0, m_b = '0, m_sum = '0;
  logic         m_sub = 1'b0, m_cout = 1'b0, m_ovf = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase <= 0;
      m_sum   <= '0;
      m_cout  <= 1'b0;
      m_ovf   <= 1'b0;
    end else if (m_phase == 0) begin
      if (req_valid) begin
        m_a     <= req_a;
        m_b     <= req_b;
        m_sub   <= req_sub;
        m_phase <= 1;
      end
    end else if (m_phase < NW) begin
      m_phase <= m_phase + 1;
    end else if (m_phase == NW) begin
      m_sum   <= ref_sum(m_a, m_b, m_sub);
      m_cout  <= ref_cout(m_a, m_b, m_sub);
      m_ovf   <= ref_ovf(m_a, m_b, m_sub);
      m_phase <= NW + 1;
    end else if (rsp_ready) begin
      m_phase <= 0;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      logic [DW-1:0] e1, e2;
      logic          ec;
      int            k;
      e1 = '0; e2 = '0; ec = 1'b0;
      if (m_phase >= 1 && m_phase <= NW) begin
        k  = m_phase - 1;
        e1 = m_a[k*DW +: DW];
        e2 = m_sub ? ~m_b[k*DW +: DW] : m_b[k*DW +: DW];
        ec = carry_into(m_a, m_b, m_sub, k);
      end
      chk("req_ready", req_ready, m_phase == 0);
      chk("busy", busy, m_phase != 0);
      chk("rsp_valid", rsp_valid, m_phase == NW + 1);
      chk("rsp_sum", rsp_sum, m_sum);
      chk("rsp_cout", rsp_cout, m_cout);
      chk("rsp_ovf", rsp_ovf, m_ovf);
      chk("add_in1", add_in1, e1);
      chk("add_in2", add_in2, e2);
      chk("add_cin", add_cin, ec);
    end
  end

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (req_ready) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL idle_timeout actual=req_ready_low expected=req_ready_high");
    end
  endtask

  task automatic wait_rsp();
    bit ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (rsp_valid) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL rsp_timeout actual=rsp_valid_low expected=rsp_valid_high");
    end
  endtask

  // Issue from a negedge while idle; returns just after the accepting edge.
  task automatic issue(input logic [W-1:0] a, b, input logic sub);
    wait_idle();
    req_valid = 1'b1; req_a = a; req_b = b; req_sub = sub; rsp_ready = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_a = {$urandom, $urandom}; req_b = {$urandom, $urandom}; req_sub = $urandom_range(0, 1);
  endtask

  task automatic handshake();
    @(posedge clk); #1 rsp_ready = 1'b1;
    @(posedge clk); #1 rsp_ready = 1'b0;
  endtask

  task automatic directed(input string nm, input logic [W-1:0] a, b, input logic sub,
                          input logic [W-1:0] es, input logic ec, eo,
                          input bit chk_cin, input logic [3:0] ecin);
    issue(a, b, sub);
    for (int k = 0; k < NW; k++) begin
      @(negedge clk);
      if (chk_cin) chk({nm, "_cin"}, add_cin, ecin[k]);
    end
    @(negedge clk);
    chk({nm, "_valid_T5"}, rsp_valid, 1'b1);
    chk({nm, "_sum"}, rsp_sum, es);
    chk({nm, "_cout"}, rsp_cout, ec);
    chk({nm, "_ovf"}, rsp_ovf, eo);
    chk({nm, "_model_sum"}, m_sum, es);
    handshake();
  endtask

  function automatic logic [W-1:0] rnd_operand();
    case ($urandom_range(0, 5))
      0:       return '1;
      1:       return '0;
      2:       return 64'h8000_0000_0000_0000;
      3:       return 64'h7FFF_FFFF_FFFF_FFFF;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  initial begin
    #400000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    req_valid = 1'b0; req_sub = 1'b0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    cmp_en = 1'b1;
    @(negedge clk);
    chk("rst_req_ready", req_ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_rsp_sum", rsp_sum, '0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Reset during the second RUN cycle aborts the operation.
    issue(64'h1234_5678_9ABC_DEF0, 64'h1111_1111_1111_1111, 1'b0);
    @(posedge clk); #1 rst_n = 1'b0;
    #1;
    chk("abort_req_ready", req_ready, 1'b1);
    chk("abort_busy", busy, 1'b0);
    chk("abort_add_in1", add_in1, '0);
    chk("abort_add_in2", add_in2, '0);
    chk("abort_add_cin", add_cin, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("abort_no_rsp", rsp_valid, 1'b0);
    end

    directed("carry1", 64'h0000_0000_0000_FFFF, 64'h1, 1'b0,
             64'h0000_0000_0001_0000, 1'b0, 1'b0, 1'b1, 4'b0010);
    directed("allones", '1, '1, 1'b0,
             64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 1'b0, 1'b1, 4'b1110);
    directed("posovf", 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0,
             64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b1, 4'b1110);
    directed("sub0m1", 64'h0, 64'h1, 1'b1,
             64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b1, 4'b0001);
    directed("sub5m3", 64'h5, 64'h3, 1'b1,
             64'h2, 1'b1, 1'b0, 1'b1, 4'b1111);
    directed("negovf", 64'h8000_0000_0000_0000, 64'h1, 1'b1,
             64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 1'b0, 4'b0000);

    // Backpressure: response held with a competing request pending.
    issue(64'h3, 64'h4, 1'b0);
    wait_rsp();
    req_valid = 1'b1; req_a = 64'h10; req_b = 64'h20; req_sub = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("hold_valid", rsp_valid, 1'b1);
      chk("hold_sum", rsp_sum, 64'h7);
      chk("hold_req_ready", req_ready, 1'b0);
    end
    handshake();
    @(negedge clk);
    chk("post_idle_ready", req_ready, 1'b1);
    chk("post_idle_busy", busy, 1'b0);
    chk("post_keep_sum", rsp_sum, 64'h7);
    @(posedge clk); #1 req_valid = 1'b0;
    @(negedge clk);
    chk("post_accept_busy", busy, 1'b1);
    wait_rsp();
    chk("post_sum", rsp_sum, 64'h30);
    handshake();

    for (int n = 0; n < 60; n++) begin
      wait_idle();
      rsp_ready = $urandom_range(0, 1);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      issue(rnd_operand(), rnd_operand(), $urandom_range(0, 1));
      wait_rsp();
      repeat ($urandom_range(0, 3)) @(negedge clk);
      handshake();
    end

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
